// File: rtl/byte_to_word_fifo_if.sv
// ---------------------------------------------------------------------------
// byte_to_word_fifo_if
//
// Purpose: groups the byte-write / word-read signals of byte_to_word_fifo.
//
// Parameters:
//   DEPTH     word capacity of the attached FIFO (power of two, >= 4)
//
// Signals:
//   WRITE     byte write strobe (source -> FIFO)
//   DATA_IN   8-bit byte to write (source -> FIFO)
//   READ      word pop strobe (sink -> FIFO)
//   DATA_OUT  32-bit head word, 0 while EMPTY (FIFO -> sink)
//   FULL      storage holds DEPTH words (FIFO -> source)
//   EMPTY     no complete word stored (FIFO -> sink)
//   SIZE      number of complete words stored (FIFO -> both)
//
// Modports:
//   master    the byte source / word sink side
//   slave     the FIFO itself
// ---------------------------------------------------------------------------
interface byte_to_word_fifo_if #(
    parameter int DEPTH = 1024
);
    localparam int SW = $clog2(DEPTH) + 1;

    logic          WRITE;
    logic [7:0]    DATA_IN;
    logic          READ;
    logic [31:0]   DATA_OUT;
    logic          FULL;
    logic          EMPTY;
    logic [SW-1:0] SIZE;

    modport master (
        output WRITE,
        output DATA_IN,
        output READ,
        input  DATA_OUT,
        input  FULL,
        input  EMPTY,
        input  SIZE
    );

    modport slave (
        input  WRITE,
        input  DATA_IN,
        input  READ,
        output DATA_OUT,
        output FULL,
        output EMPTY,
        output SIZE
    );
endinterface

// File: rtl/byte_to_word_fifo.sv
// ---------------------------------------------------------------------------
// byte_to_word_fifo
//
// Purpose: byte-wide write, 32-bit read, first-word-fall-through FIFO.
// Accepted bytes are packed four at a time into a word which is pushed
// into a DEPTH-word circular buffer. A partially packed word is invisible
// to SIZE / EMPTY / FULL.
//
// Parameters:
//   DEPTH  word capacity, power of two, at least 4
//
// Ports:
//   CLK    single clock, rising edge
//   RST    synchronous active-high reset (pointers, lane, SIZE, assembly)
//   bus    byte_to_word_fifo_if.slave:
//            WRITE/DATA_IN   byte input, accepted when FULL=0
//            READ            pop, honoured when EMPTY=0
//            DATA_OUT        head word (0 while EMPTY)
//            FULL/EMPTY/SIZE occupancy in complete words
//
// Build option:
//   BYTE_TO_WORD_MSB_FIRST_EN  when defined, the first byte of a word lands
//                              in [31:24] (big-endian); otherwise the first
//                              byte lands in [7:0] (little-endian).
// ---------------------------------------------------------------------------
module byte_to_word_fifo #(
    parameter int DEPTH = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    byte_to_word_fifo_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] DEPTH_SZ = SW'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]    lane_q,   lane_d;
    logic [23:0]   asm_q,    asm_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SW-1:0] size_q,   size_d;

    logic [31:0]   mem [DEPTH];

    logic          full_w;
    logic          empty_w;
    logic          accept_w;
    logic          push_w;
    logic          pop_w;
    logic [31:0]   push_word_w;

    // -----------------------------------------------------------------------
    // Byte placement helpers. The assembly register only ever holds the
    // first three bytes of a word; the fourth byte goes straight into the
    // pushed word, so lane 3 never writes the assembly register.
    // -----------------------------------------------------------------------
    function automatic logic [23:0] insert_byte(
        input logic [23:0] asm_in,
        input logic [1:0]  lane,
        input logic [7:0]  b
    );
        logic [23:0] r;
        r = asm_in;
`ifdef BYTE_TO_WORD_MSB_FIRST_EN
        case (lane)
            2'd0:    r[23:16] = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[7:0]   = b;
            default: r        = asm_in;
        endcase
`else
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r        = asm_in;
        endcase
`endif
        return r;
    endfunction

    function automatic logic [31:0] pack_word(
        input logic [23:0] asm_in,
        input logic [7:0]  last_byte
    );
`ifdef BYTE_TO_WORD_MSB_FIRST_EN
        return {asm_in, last_byte};
`else
        return {last_byte, asm_in};
`endif
    endfunction

    // -----------------------------------------------------------------------
    // Handshake decode. FULL/EMPTY come from the registered SIZE, so a pop
    // in the same cycle does not open room for a byte until the next cycle.
    // -----------------------------------------------------------------------
    assign full_w      = (size_q == DEPTH_SZ);
    assign empty_w     = (size_q == '0);
    assign accept_w    = bus.WRITE && !full_w;
    assign push_w      = accept_w && (lane_q == 2'd3);
    assign pop_w       = bus.READ && !empty_w;
    assign push_word_w = pack_word(asm_q, bus.DATA_IN);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        lane_d   = lane_q;
        asm_d    = asm_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        size_d   = size_q;

        if (accept_w) begin
            lane_d = lane_q + 2'd1;
            if (push_w) begin
                asm_d = '0;
            end else begin
                asm_d = insert_byte(asm_q, lane_q, bus.DATA_IN);
            end
        end

        if (push_w) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_w, pop_w})
            2'b10:   size_d = size_q + SW'(1);
            2'b01:   size_d = size_q - SW'(1);
            default: size_d = size_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            lane_q   <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
        end else begin
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            size_q   <= size_d;
        end
    end

    // -----------------------------------------------------------------------
    // Word storage (contents survive reset; only the pointers are cleared)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST && push_w) begin
            mem[wr_ptr_q] <= push_word_w;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: head word falls through combinationally
    // -----------------------------------------------------------------------
    assign bus.DATA_OUT = empty_w ? 32'h0 : mem[rd_ptr_q];
    assign bus.FULL     = full_w;
    assign bus.EMPTY    = empty_w;
    assign bus.SIZE     = size_q;

endmodule

// File: tb/tb_byte_to_word_fifo.sv
module tb_byte_to_word_fifo;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    byte_to_word_fifo_if #(.DEPTH(DEPTH)) bus ();

    byte_to_word_fifo #(.DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Hand-computed literal words
`ifdef BYTE_TO_WORD_MSB_FIRST_EN
    localparam logic [31:0] W_01020304 = 32'h01020304;
    localparam logic [31:0] W_AA       = 32'h010203AA;
    localparam logic [31:0] W_11223344 = 32'h11223344;
    localparam logic [31:0] F0 = 32'h00010203;
    localparam logic [31:0] F1 = 32'h04050607;
    localparam logic [31:0] F2 = 32'h08090A0B;
    localparam logic [31:0] F3 = 32'h0C0D0E0F;
`else
    localparam logic [31:0] W_01020304 = 32'h04030201;
    localparam logic [31:0] W_AA       = 32'hAA030201;
    localparam logic [31:0] W_11223344 = 32'h44332211;
    localparam logic [31:0] F0 = 32'h03020100;
    localparam logic [31:0] F1 = 32'h07060504;
    localparam logic [31:0] F2 = 32'h0B0A0908;
    localparam logic [31:0] F3 = 32'h0F0E0D0C;
`endif

    function automatic logic [31:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
`ifdef BYTE_TO_WORD_MSB_FIRST_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: a queue of complete words and a queue of pending
    // bytes. Acceptance decisions use the word count from before the edge.
    // -----------------------------------------------------------------------
    logic [31:0] mq[$];
    logic [7:0]  bq[$];

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            bq.delete();
        end else begin
            if (bus.WRITE && mq.size() < DEPTH) bq.push_back(bus.DATA_IN);
            if (bus.READ && mq.size() != 0) void'(mq.pop_front());
            if (bq.size() == 4) begin
                mq.push_back(pack4(bq[0], bq[1], bq[2], bq[3]));
                bq.delete();
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_empty", 32'(bus.EMPTY), 32'(mq.size() == 0));
            chk("cyc_full",  32'(bus.FULL),  32'(mq.size() == DEPTH));
            chk("cyc_size",  32'(bus.SIZE),  32'(mq.size()));
            chk("cyc_data",  bus.DATA_OUT,   (mq.size() == 0) ? 32'h0 : mq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        bus.WRITE   = 1'b1;
        bus.DATA_IN = b;
        tick();
        bus.WRITE   = 1'b0;
    endtask

    task automatic pop();
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] got_q[$];
    bit saw_full;

    initial begin
        rst         = 1'b1;
        bus.WRITE   = 1'b0;
        bus.DATA_IN = 8'h00;
        bus.READ    = 1'b0;
        tick();
        do_reset();
        chk_en = 1'b1;

        // Reset state
        chk("rst_size",  32'(bus.SIZE),  32'd0);
        chk("rst_empty", 32'(bus.EMPTY), 32'd1);
        chk("rst_full",  32'(bus.FULL),  32'd0);
        chk("rst_data",  bus.DATA_OUT,   32'h0);

        // Four bytes -> one word, visible one cycle after the 4th byte
        bus.WRITE = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.DATA_IN = 8'(i);
            if (i == 4) chk("w4_pre_empty", 32'(bus.EMPTY), 32'd1);
            tick();
        end
        bus.WRITE = 1'b0;
        chk("w4_empty", 32'(bus.EMPTY), 32'd0);
        chk("w4_data",  bus.DATA_OUT,   W_01020304);
        chk("w4_size",  32'(bus.SIZE),  32'd1);
        pop();
        chk("w4_popped", 32'(bus.EMPTY), 32'd1);

        // Partial word is invisible, completed after idle gap
        wr(8'h01); wr(8'h02); wr(8'h03);
        chk("part_empty", 32'(bus.EMPTY), 32'd1);
        chk("part_size",  32'(bus.SIZE),  32'd0);
        chk("part_data",  bus.DATA_OUT,   32'h0);
        repeat (10) tick();
        chk("part_idle_empty", 32'(bus.EMPTY), 32'd1);
        wr(8'hAA);
        chk("part_done", bus.DATA_OUT, W_AA);
        pop();

        // Fill to FULL, rejected byte, drain
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("fill_full", 32'(bus.FULL), 32'd1);
        chk("fill_size", 32'(bus.SIZE), 32'd4);
        wr(8'hFF);
        chk("fill_rej_size", 32'(bus.SIZE), 32'd4);
        chk("fill_d0", bus.DATA_OUT, F0); pop();
        chk("fill_d1", bus.DATA_OUT, F1); pop();
        chk("fill_d2", bus.DATA_OUT, F2); pop();
        chk("fill_d3", bus.DATA_OUT, F3); pop();
        chk("drain_empty", 32'(bus.EMPTY), 32'd1);
        chk("drain_data",  bus.DATA_OUT,   32'h0);

        // Read while empty is a no-op
        pop();
        chk("eread_size",  32'(bus.SIZE),  32'd0);
        chk("eread_empty", 32'(bus.EMPTY), 32'd1);

        // Read and write together while FULL: pop happens, byte rejected
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("rf_full", 32'(bus.FULL), 32'd1);
        bus.READ    = 1'b1;
        bus.WRITE   = 1'b1;
        bus.DATA_IN = 8'h55;
        tick();
        bus.READ    = 1'b0;
        bus.WRITE   = 1'b0;
        chk("rf_size", 32'(bus.SIZE), 32'd3);
        chk("rf_full_after", 32'(bus.FULL), 32'd0);
        chk("rf_head", bus.DATA_OUT, F1);
        do_reset();
        chk("rf_rst_size", 32'(bus.SIZE), 32'd0);

        // Pointer wrap: 40 bytes streamed with READ held high
        saw_full = 1'b0;
        got_q.delete();
        bus.READ = 1'b1;
        for (int i = 0; i < 44; i++) begin
            bus.WRITE   = (i < 40);
            bus.DATA_IN = 8'(8'h80 + i);
            if (!bus.EMPTY) got_q.push_back(bus.DATA_OUT);
            if (bus.FULL) saw_full = 1'b1;
            tick();
        end
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
        chk("wrap_count", 32'(got_q.size()), 32'd10);
        chk("wrap_never_full", 32'(saw_full), 32'd0);
        for (int k = 0; k < 10 && k < got_q.size(); k++) begin
            chk($sformatf("wrap_w%0d", k), got_q[k],
                pack4(8'(8'h80 + 4*k), 8'(8'h81 + 4*k), 8'(8'h82 + 4*k), 8'(8'h83 + 4*k)));
        end
        chk("wrap_end_empty", 32'(bus.EMPTY), 32'd1);

        // Reset mid-word discards partial bytes
        wr(8'hE1); wr(8'hE2);
        do_reset();
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        chk("rmid_data", bus.DATA_OUT, W_11223344);
        chk("rmid_size", 32'(bus.SIZE), 32'd1);
        pop();
        chk("rmid_empty", 32'(bus.EMPTY), 32'd1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/byte_to_word_fifo.md
# byte_to_word_fifo

Byte-wide write, 32-bit-wide read FIFO. Incoming bytes are packed four at a time into 32-bit words, and the words are stored in a DEPTH-word circular buffer. It sits between a byte source (typically the read side of a clock-domain-crossing FIFO) and a 32-bit readout FIFO that pops words with a read-next handshake. Output is first-word-fall-through.

## Interface
- DEPTH, default 1024: word capacity of the storage; power of two, at least 4.
- CLK  input  1  the single clock; all logic is clocked on the rising edge.
- RST  input  1  synchronous, active-high reset.
- WRITE  input  1  byte write strobe; accepted only when FULL=0.
- DATA_IN  input  8  byte written when WRITE is accepted.
- READ  input  1  pop strobe; honoured only when EMPTY=0.
- DATA_OUT  output  32  head word of the FIFO; 0 while EMPTY=1.
- FULL  output  1  storage holds DEPTH words; no bytes are accepted.
- EMPTY  output  1  no complete word is stored.
- SIZE  output  clog2(DEPTH)+1  number of complete words stored.

## Operation
- Byte lane counter `lane` runs 0..3. Every accepted byte is written to lane `lane` of a 24-bit assembly register, and the counter increments modulo 4.
- Default packing is little-endian. Byte 0 goes to [7:0], byte 1 to [15:8], byte 2 to [23:16] and byte 3 to [31:24].
- When a byte is accepted with lane=3, the word is {DATA_IN, assembly[23:0]}. It is pushed into storage in the same cycle, and lane returns to 0.
- Storage is a DEPTH x 32 memory with write and read pointers of clog2(DEPTH) bits. Both pointers wrap modulo DEPTH.
- SIZE is a registered counter:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- FULL = (SIZE==DEPTH).
- EMPTY = (SIZE==0).
- DATA_OUT = mem[rd_ptr] when EMPTY=0, otherwise 32'h0.
- Pop: READ && !EMPTY. It advances rd_ptr.
- READ while EMPTY is ignored. There is no underflow error and no state change.
- WRITE while FULL is ignored. The byte is not stored, lane does not advance, and no error is raised. Upstream must hold the byte.
- FULL blocks every byte, including bytes for lanes 0..2. Partial words are never accepted while FULL.
- A partially assembled word (lane != 0) is invisible: it does not count in SIZE and does not affect EMPTY.

## Timing
- Reset values, applied on the clock edge with RST=1:
  - SIZE=0, EMPTY=1, FULL=0, DATA_OUT=0.
  - lane=0, both pointers 0.
  - The assembly register is cleared.
  - Memory contents are not cleared.
- RST has priority over WRITE and READ in the same cycle.
- Reset mid-word discards the partial bytes.
- Write latency: after the edge accepting the 4th byte, EMPTY falls and DATA_OUT shows the word. This is one cycle.
- Read: DATA_OUT is valid combinationally while EMPTY=0. On the edge with READ=1, the next word (or 0 if none) appears after that edge.
- Push and pop in the same cycle while 0<SIZE<DEPTH: both happen and SIZE is unchanged.
- Push with READ while EMPTY: the push occurs and the read is ignored. EMPTY falls on the next cycle.
- Push while FULL with READ in the same cycle: the pop occurs and the byte is rejected. FULL is evaluated from registered SIZE. The byte is accepted one cycle later.
- Throughput: one byte per cycle in, one word per cycle out.

## Configuration
- BYTE_TO_WORD_MSB_FIRST_EN defined: big-endian packing. Byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8] and byte 3 to [7:0].
- BYTE_TO_WORD_MSB_FIRST_EN not defined: the default little-endian packing described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then write 0x01,0x02,0x03,0x04 on consecutive cycles.
  - EMPTY falls one cycle after the 4th byte, DATA_OUT=0x04030201 and SIZE=1.
  - With BYTE_TO_WORD_MSB_FIRST_EN, DATA_OUT=0x01020304.
- Write 3 bytes only.
  - EMPTY stays 1, SIZE=0 and DATA_OUT=0.
  - A 4th byte 0xAA after 10 idle cycles completes the word 0xAA030201 (bytes 0x01,0x02,0x03 then 0xAA).
- Fill with DEPTH=4 using bytes 0x00..0x0F.
  - FULL=1 and SIZE=4.
  - A further WRITE of 0xFF is ignored.
  - Four pops return 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, and EMPTY=1 afterwards.
- Pointer wrap with DEPTH=4: stream 40 bytes with continuous READ. All 10 words come out in order with correct values, and FULL is never asserted.
- Write 2 bytes, assert RST for one cycle, then write 0x11,0x22,0x33,0x44. The word read is 0x44332211, and no stale bytes appear.
- READ while EMPTY, then READ while FULL together with a WRITE (DEPTH=4).
  - The empty read is a no-op and SIZE stays 0.
  - In the full case the pop occurs, the byte is rejected, and SIZE goes 4→3.
